// File: rtl/uart_pkg.sv
// Shared encodings and constants for the UART receive path.
// State codes and oversampling points used by the receiver FSM.
package uart_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t START = 2'd1;
  localparam state_t DATA  = 2'd2;
  localparam state_t STOP  = 2'd3;

  localparam int START_MID  = 7;
  localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Receive-buffer handshake towards the interface stage.
// master = receive buffer, slave = consumer popping bytes.
interface uart_rx_buffer_if #(
  parameter int DBIT = 8
);
  logic            i_rd_uart;
  logic [DBIT-1:0] o_r_data;
  logic            o_rx_empty;
  logic            o_rx_full;
  logic            o_frame_err;
  logic            o_overrun;

  modport master (
    input  i_rd_uart,
    output o_r_data,
    output o_rx_empty,
    output o_rx_full,
    output o_frame_err,
    output o_overrun
  );

  modport slave (
    output i_rd_uart,
    input  o_r_data,
    input  o_rx_empty,
    input  o_rx_full,
    input  o_frame_err,
    input  o_overrun
  );
endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with extra-MSB pointers.
// A pop frees the slot a same-cycle push needs when full.
module sync_fifo #(
  parameter int DBIT    = 8,
  parameter int FIFO_AW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [DBIT-1:0] wdata,
  output logic [DBIT-1:0] rdata,
  output logic            empty,
  output logic            full
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [FIFO_AW:0] wp;
  logic [FIFO_AW:0] rp;
  logic [DBIT-1:0]  mem [DEPTH];
  logic             rd_en;
  logic             wr_en;

  assign empty = (wp == rp);
  assign full  = (wp[FIFO_AW] != rp[FIFO_AW]) &&
                 (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rp[FIFO_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wp[FIFO_AW-1:0]] <= wdata;
        wp <= wp + 1'b1;
      end
      if (rd_en) begin
        rp <= rp + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver with 16x oversampling feeding a small FIFO.
// Head of FIFO is presented to the interface stage via the bus.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_AW = 2
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_rx,
  input  logic i_s_tick,
  uart_rx_buffer_if.master bus
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            push;
  logic            full;
  logic            frame_err;
  logic            overrun;

  // Good stop bit on its sample tick
  assign push = (state == STOP) && i_s_tick &&
                (s == SW'(SB_TICK - 1)) && i_rx;

  sync_fifo #(
    .DBIT    (DBIT),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clock),
    .rst_n (i_reset),
    .push  (push),
    .pop   (bus.i_rd_uart),
    .wdata (b),
    .rdata (bus.o_r_data),
    .empty (bus.o_rx_empty),
    .full  (full)
  );

  assign bus.o_rx_full   = full;
  assign bus.o_frame_err = frame_err;
  assign bus.o_overrun   = overrun;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      b         <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= push && full && !bus.i_rd_uart;
      unique case (state)
        IDLE: begin
          if (!i_rx) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (i_s_tick) begin
            if (s == SW'(START_MID)) begin
              s <= '0;
              n <= '0;
              state <= i_rx ? IDLE : DATA;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_s_tick) begin
            if (s == SW'(OVERSAMPLE - 1)) begin
              s <= '0;
              b <= {i_rx, b[DBIT-1:1]};
              if (n == NW'(DBIT - 1)) begin
                state <= STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (i_s_tick) begin
            if (s == SW'(SB_TICK - 1)) begin
              state     <= IDLE;
              frame_err <= !i_rx;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
UART receive front end that feeds the ALU interface stage.
- Deserialises 8N1 frames from the serial line using a 16x oversampling tick from the baud-rate generator.
- Pushes each good byte into a small FIFO.
- Exposes the FIFO head through the rx_empty / r_data / rd_uart handshake that the interface stage consumes: opcode, then data A, then data B.

Parameters:
DBIT, 8, data bits per frame (LSB first)
SB_TICK, 16, oversampling ticks spanning the stop bit
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW = 4

Ports:
clock  input  1  system clock; all state on rising edge
i_reset  input  1  asynchronous, active-low reset (0 = reset asserted)
i_rx  input  1  serial line, idle high; treated as already synchronised
i_s_tick  input  1  one-cycle pulse at 16x baud rate; may be held high (one tick per clock)
i_rd_uart  input  1  pop request from interface stage; ignored when empty
o_r_data  output  DBIT  FIFO head, first-word fall-through
o_rx_empty  output  1  FIFO empty
o_rx_full  output  1  FIFO full
o_frame_err  output  1  one-cycle pulse: stop bit sampled low
o_overrun  output  1  one-cycle pulse: good byte dropped because FIFO full

Behaviour:
Reset (i_reset=0, async):
- FSM to IDLE; tick counter s, bit counter n and shift register cleared.
- FIFO pointers and storage cleared.
- Outputs: o_rx_empty=1, o_rx_full=0, o_r_data=0, o_frame_err=0, o_overrun=0.
- Reset mid-frame abandons the partial byte. No push occurs.

Receiver FSM (s and n advance only on cycles with i_s_tick=1):
- IDLE: when i_rx=0, go to START with s=0. No tick is required to leave IDLE.
- START: at the tick where s==7 (mid start bit):
  - if i_rx=0: go to DATA with s=0, n=0;
  - else glitch: return to IDLE, nothing pushed.
  - Otherwise s++.
- DATA: at s==15, shift i_rx into the MSB of the shift register (right shift, so LSB arrives first), set s=0 and n++. After the sample with n==DBIT-1, go to STOP.
- STOP: at s==SB_TICK-1, sample i_rx and go to IDLE:
  - if i_rx=1: the byte is good and is pushed;
  - if i_rx=0: o_frame_err pulses for one cycle and the byte is discarded.

Push / pop latency:
- A pushed byte is visible on o_r_data, with o_rx_empty=0, on the clock edge after the stop-sample tick.
- Pop: with i_rd_uart=1 and not empty, the read pointer advances at the clock edge. The next entry, or empty, is visible the following cycle.

FIFO boundary conditions:
- Push while full and no pop: byte dropped, o_overrun pulses, contents unchanged.
- Push and pop in the same cycle while full: both happen, occupancy stays full, no overrun.
- Push and pop in the same cycle while empty: the pop is ignored and the push is written.
- Pop while empty: no effect.
- Pointers are FIFO_AW+1 bits wide and wrap naturally. Full/empty are derived from the MSB and the address bits.
- o_rx_full and o_rx_empty are registered-pointer functions with no extra latency.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE, START, DATA, STOP) as 2-bit localparams;
  - the constant START_MID = 7 and the constant OVERSAMPLE = 16.
- One sub-module: sync_fifo (parameters DBIT and FIFO_AW; ports push, pop, wdata, rdata, empty, full).
- The receiver FSM stays in uart_rx_buffer.

Test Plan:
All scenarios hold i_s_tick high (16 clocks per bit) unless stated otherwise.
1. Reset: hold i_reset=0 then release -> o_rx_empty=1, o_rx_full=0, o_r_data=8'h00, both error pulses 0.
2. Single frame 8'h20 (bits 0,0,0,0,0,1,0,0, stop=1), then one-cycle i_rd_uart -> o_rx_empty falls one edge after the stop sample with o_r_data=8'h20; o_rx_empty returns to 1 after the pop.
3. Back-to-back frames 8'h20, 8'h01, 8'h02 with no reads; then pop three times -> o_r_data reads 8'h20, 8'h01, 8'h02 in order, then o_rx_empty=1.
4. Frames 8'h11, 8'h22, 8'h33, 8'h44 fill the FIFO (o_rx_full=1); then send 8'h55 -> one o_overrun pulse; pops yield 8'h11..8'h44 only. Repeat the fill with a pop coincident with the 5th push -> no overrun, 8'h55 retained.
5. Frame 8'hA5 with stop bit 0 -> one o_frame_err pulse, o_rx_empty stays 1.
6. Glitch and reset:
   - i_rx low for 4 ticks then high -> nothing received, FSM back in IDLE.
   - Assert i_reset mid-DATA of 8'h7E -> empty, idle; next clean frame 8'h3C is received correctly.
   - Rerun scenario 2 with i_s_tick pulsing every 3rd clock -> same data.
